queue_fifo_ctr: RTL and testbench

Parametrised synchronous FIFO: next-generation queue for the datapath buffers. Improvements over the current queue:
- Uses all 2**ADDR_W entries instead of leaving one slot empty.
- Keeps an occupancy count and almost-full/almost-empty flags with programmable thresholds.
- Offers a registered-read mode and a first-word-fall-through (FWFT) mode.
- Records overflow and underflow in sticky error bits.
- Has a synchronous flush.

Sits between producer and consumer stages in the same clock domain.

---
 rtl/queue_fifo_ctr.sv | 135 +++++++++++++
 tb/tb_queue_fifo_ctr.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/queue_fifo_ctr.sv
// Synchronous FIFO using all 2**ADDR_W slots, with an occupancy count, threshold flags,
// sticky overflow/underflow bits, synchronous flush and a registered or FWFT read port.
module queue_fifo_ctr #(
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 4,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              err_clr,
  input  logic              push,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              pop,
  output logic [WIDTH-1:0]  data_out,
  output logic              valid_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   AFULL_C   = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0]   AEMPTY_C  = AEMPTY_TH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
  localparam logic [ADDR_W:0]   CNT_ONE   = 1;

  if (AEMPTY_TH < 0 || AEMPTY_TH >= AFULL_TH || AFULL_TH > DEPTH) begin : g_bad_cfg
    $fatal(1, "queue_fifo_ctr: thresholds must satisfy 0 <= AEMPTY_TH < AFULL_TH <= DEPTH");
  end

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic w_full;
  logic w_empty;
  logic w_pop_acc;
  logic w_push_acc;
  logic w_pop_do;
  logic w_push_do;
  logic w_ovf_set;
  logic w_udf_set;

  // Count never exceeds DEPTH, so its MSB alone marks full.
  assign w_full  = r_count[ADDR_W];
  assign w_empty = (r_count == '0);

  assign w_pop_acc  = pop & ~w_empty;
  assign w_push_acc = push & (~w_full | w_pop_acc);
  assign w_pop_do   = w_pop_acc & ~flush;
  assign w_push_do  = w_push_acc & ~flush;
  assign w_ovf_set  = push & ~w_push_acc & ~flush;
  assign w_udf_set  = pop & ~w_pop_acc & ~flush;

  always_ff @(posedge clk) begin
    if (w_push_do) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_do) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_do)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push_do, w_pop_do})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // A fresh error in the same cycle takes precedence over err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)    r_overflow <= 1'b1;
      else if (err_clr) r_overflow <= 1'b0;
      if (w_udf_set)    r_underflow <= 1'b1;
      else if (err_clr) r_underflow <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out  = r_mem[r_rd_ptr];
    assign valid_out = ~w_empty;
  end else begin : g_reg_read
    logic [WIDTH-1:0] r_data_out;
    logic             r_valid_out;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_data_out  <= '0;
        r_valid_out <= 1'b0;
      end else if (w_pop_do) begin
        r_data_out  <= r_mem[r_rd_ptr];
        r_valid_out <= 1'b1;
      end else begin
        r_valid_out <= 1'b0;
      end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
  end

  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AFULL_C);
  assign almost_empty = (r_count <= AEMPTY_C);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_queue_fifo_ctr.sv
// Directed bench for queue_fifo_ctr: a registered-read instance (u0) and an FWFT instance (u1),
// both DEPTH=4 with AFULL_TH=3 and AEMPTY_TH=1.
module tb_queue_fifo_ctr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       f0, e0c, p0, q0;
  logic [7:0] d0;
  logic [7:0] o0_data;
  logic       o0_valid, o0_full, o0_empty, o0_af, o0_ae, o0_ovf, o0_udf;
  logic [2:0] o0_count;

  logic       f1, e1c, p1, q1;
  logic [7:0] d1;
  logic [7:0] o1_data;
  logic       o1_valid, o1_full, o1_empty, o1_af, o1_ae, o1_ovf, o1_udf;
  logic [2:0] o1_count;

  wire [3:0] fl0 = {o0_full, o0_empty, o0_af, o0_ae};

  queue_fifo_ctr #(.WIDTH(8), .ADDR_W(2), .FWFT(0), .AFULL_TH(3), .AEMPTY_TH(1)) u0 (
    .clk(clk), .rst(rst), .flush(f0), .err_clr(e0c), .push(p0), .data_in(d0), .pop(q0),
    .data_out(o0_data), .valid_out(o0_valid), .count(o0_count), .full(o0_full),
    .empty(o0_empty), .almost_full(o0_af), .almost_empty(o0_ae),
    .overflow(o0_ovf), .underflow(o0_udf)
  );

  queue_fifo_ctr #(.WIDTH(8), .ADDR_W(2), .FWFT(1), .AFULL_TH(3), .AEMPTY_TH(1)) u1 (
    .clk(clk), .rst(rst), .flush(f1), .err_clr(e1c), .push(p1), .data_in(d1), .pop(q1),
    .data_out(o1_data), .valid_out(o1_valid), .count(o1_count), .full(o1_full),
    .empty(o1_empty), .almost_full(o1_af), .almost_empty(o1_ae),
    .overflow(o1_ovf), .underflow(o1_udf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    f0 = 0; e0c = 0; p0 = 0; q0 = 0; d0 = 0;
    f1 = 0; e1c = 0; p1 = 0; q1 = 0; d1 = 0;
    rst = 1;
    step(); step();
    total++; if (o0_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", o0_count); end
    total++; if (fl0 !== 4'b0101) begin bad++; $display("FAIL reset_flags got=%b exp=0101", fl0); end
    total++; if ({o0_valid, o0_data} !== 9'h000) begin bad++; $display("FAIL reset_out got=%b/%h exp=0/00", o0_valid, o0_data); end
    total++; if ({o0_ovf, o0_udf} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", {o0_ovf, o0_udf}); end
    total++; if ({o1_valid, o1_empty} !== 2'b01) begin bad++; $display("FAIL reset_fwft got=%b exp=01", {o1_valid, o1_empty}); end
    rst = 0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_fill();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [3:0] flg  [4] = '{4'b0001, 4'b0000, 4'b0010, 4'b1010};
    for (int k = 0; k < 4; k++) begin
      p0 = 1; d0 = vals[k];
      step();
      total++; if (o0_count !== 3'(k + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", k, o0_count, k + 1); end
      total++; if (fl0 !== flg[k]) begin bad++; $display("FAIL fill_flags[%0d] got=%b exp=%b", k, fl0, flg[k]); end
      $display("push %h count=%0d flags=%b", vals[k], o0_count, fl0);
    end
    d0 = 8'h55;
    step();
    p0 = 0;
    total++; if (o0_count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", o0_count); end
    total++; if (o0_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", o0_ovf); end
    $display("push 55 rejected overflow=%b", o0_ovf);
  endtask

  task automatic test_drain();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    q0 = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if ({o0_valid, o0_data} !== {1'b1, vals[k]}) begin bad++; $display("FAIL drain_data[%0d] got=%b/%h exp=1/%h", k, o0_valid, o0_data, vals[k]); end
      total++; if (o0_count !== 3'(3 - k)) begin bad++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", k, o0_count, 3 - k); end
      $display("pop data=%h valid=%b count=%0d", o0_data, o0_valid, o0_count);
    end
    step();
    q0 = 0;
    total++; if (o0_udf !== 1'b1) begin bad++; $display("FAIL udf_flag got=%b exp=1", o0_udf); end
    total++; if ({o0_valid, o0_data} !== 9'h044) begin bad++; $display("FAIL udf_out got=%b/%h exp=0/44", o0_valid, o0_data); end
    total++; if (fl0 !== 4'b0101) begin bad++; $display("FAIL udf_flags got=%b exp=0101", fl0); end
    $display("pop on empty underflow=%b", o0_udf);
  endtask

  task automatic test_err_clr();
    e0c = 1;
    step();
    e0c = 0;
    total++; if ({o0_ovf, o0_udf} !== 2'b00) begin bad++; $display("FAIL err_clr got=%b exp=00", {o0_ovf, o0_udf}); end
    $display("err_clr ovf=%b udf=%b", o0_ovf, o0_udf);
  endtask

  task automatic test_full_pushpop();
    logic [7:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] rest [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
    for (int k = 0; k < 4; k++) begin
      p0 = 1; d0 = fill[k];
      step();
    end
    d0 = 8'h66; q0 = 1;
    step();
    p0 = 0;
    total++; if ({o0_valid, o0_data} !== 9'h111) begin bad++; $display("FAIL full_pp_data got=%b/%h exp=1/11", o0_valid, o0_data); end
    total++; if (o0_count !== 3'd4) begin bad++; $display("FAIL full_pp_count got=%0d exp=4", o0_count); end
    total++; if (o0_ovf !== 1'b0) begin bad++; $display("FAIL full_pp_ovf got=%b exp=0", o0_ovf); end
    $display("push 66 + pop on full data=%h count=%0d", o0_data, o0_count);
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if ({o0_valid, o0_data} !== {1'b1, rest[k]}) begin bad++; $display("FAIL full_drain[%0d] got=%b/%h exp=1/%h", k, o0_valid, o0_data, rest[k]); end
      $display("pop data=%h", o0_data);
    end
    q0 = 0;
    for (int i = 0; i < 10; i++) begin
      p0 = 1; d0 = 8'hC0 + 8'(i);
      step();
      p0 = 0; q0 = 1;
      step();
      q0 = 0;
      total++; if ({o0_valid, o0_data} !== {1'b1, 8'hC0 + 8'(i)}) begin bad++; $display("FAIL wrap[%0d] got=%b/%h exp=1/%h", i, o0_valid, o0_data, 8'hC0 + 8'(i)); end
      $display("round %0d data=%h count=%0d", i, o0_data, o0_count);
    end
    total++; if (o0_count !== 3'd0) begin bad++; $display("FAIL wrap_count got=%0d exp=0", o0_count); end
  endtask

  task automatic test_empty_pushpop();
    p0 = 1; q0 = 1; d0 = 8'h77;
    step();
    p0 = 0;
    total++; if (o0_udf !== 1'b1) begin bad++; $display("FAIL empty_pp_udf got=%b exp=1", o0_udf); end
    total++; if (o0_count !== 3'd1) begin bad++; $display("FAIL empty_pp_count got=%0d exp=1", o0_count); end
    total++; if (o0_valid !== 1'b0) begin bad++; $display("FAIL empty_pp_valid got=%b exp=0", o0_valid); end
    $display("push 77 + pop on empty count=%0d udf=%b", o0_count, o0_udf);
    step();
    q0 = 0;
    total++; if ({o0_valid, o0_data} !== 9'h177) begin bad++; $display("FAIL empty_pp_data got=%b/%h exp=1/77", o0_valid, o0_data); end
    $display("pop data=%h", o0_data);
  endtask

  task automatic test_fwft();
    p1 = 1; d1 = 8'hA5;
    step();
    p1 = 0;
    total++; if ({o1_valid, o1_data} !== 9'h1A5) begin bad++; $display("FAIL fwft_show got=%b/%h exp=1/a5", o1_valid, o1_data); end
    total++; if (o1_count !== 3'd1) begin bad++; $display("FAIL fwft_count got=%0d exp=1", o1_count); end
    $display("fwft push a5 data=%h valid=%b", o1_data, o1_valid);
    q1 = 1;
    step();
    q1 = 0;
    total++; if ({o1_valid, o1_empty} !== 2'b01) begin bad++; $display("FAIL fwft_pop got=%b exp=01", {o1_valid, o1_empty}); end
    $display("fwft pop valid=%b empty=%b", o1_valid, o1_empty);
  endtask

  task automatic test_flush_err();
    e0c = 1;
    step();
    e0c = 0;
    for (int k = 1; k <= 5; k++) begin
      p0 = 1; d0 = 8'(k);
      step();
    end
    p0 = 0; q0 = 1;
    step();
    q0 = 0;
    total++; if ({o0_count, o0_ovf, o0_data} !== {3'd3, 1'b1, 8'h01}) begin bad++; $display("FAIL pre_flush got=%0d/%b/%h exp=3/1/01", o0_count, o0_ovf, o0_data); end
    f0 = 1; p0 = 1; d0 = 8'h99;
    step();
    f0 = 0; p0 = 0;
    total++; if (o0_count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", o0_count); end
    total++; if (fl0 !== 4'b0101) begin bad++; $display("FAIL flush_flags got=%b exp=0101", fl0); end
    total++; if ({o0_ovf, o0_udf} !== 2'b10) begin bad++; $display("FAIL flush_err got=%b exp=10", {o0_ovf, o0_udf}); end
    total++; if ({o0_valid, o0_data} !== 9'h001) begin bad++; $display("FAIL flush_out got=%b/%h exp=0/01", o0_valid, o0_data); end
    $display("flush count=%0d ovf=%b data=%h", o0_count, o0_ovf, o0_data);
    e0c = 1;
    step();
    e0c = 0;
    total++; if (o0_ovf !== 1'b0) begin bad++; $display("FAIL clr_ovf got=%b exp=0", o0_ovf); end
    p0 = 1; d0 = 8'hAB;
    step();
    p0 = 0; q0 = 1;
    total++; if (o0_count !== 3'd1) begin bad++; $display("FAIL post_flush_count got=%0d exp=1", o0_count); end
    step();
    q0 = 0;
    total++; if ({o0_valid, o0_data} !== 9'h1AB) begin bad++; $display("FAIL post_flush_data got=%b/%h exp=1/ab", o0_valid, o0_data); end
    $display("post-flush pop data=%h", o0_data);
    for (int k = 1; k <= 5; k++) begin
      p0 = 1; d0 = 8'h20 + 8'(k);
      step();
    end
    p0 = 0; q0 = 1;
    step();
    #2 rst = 1;
    #1;
    q0 = 0;
    total++; if (o0_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", o0_count); end
    total++; if (fl0 !== 4'b0101) begin bad++; $display("FAIL rst_flags got=%b exp=0101", fl0); end
    total++; if ({o0_valid, o0_data} !== 9'h000) begin bad++; $display("FAIL rst_out got=%b/%h exp=0/00", o0_valid, o0_data); end
    total++; if ({o0_ovf, o0_udf} !== 2'b00) begin bad++; $display("FAIL rst_err got=%b exp=00", {o0_ovf, o0_udf}); end
    $display("async reset mid-burst count=%0d valid=%b ovf=%b", o0_count, o0_valid, o0_ovf);
    #1 rst = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_err_clr();
    test_full_pushpop();
    test_empty_pushpop();
    test_fwft();
    test_flush_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
